// File: rtl/polyvecl_chknorm_seq_if.sv
// ---------------------------------------------------------------------------
// polyvecl_chknorm_seq_if
// Handshake and coefficient-memory bus for the sequential polynomial-vector
// infinity-norm checker.
//   start    : request to check one vector (requester -> checker)
//   B        : signed bound, sampled when start is accepted
//   rd_en    : coefficient read strobe (checker -> memory)
//   rd_addr  : coefficient index poly*N + coef
//   rd_data  : signed coefficient, valid one cycle after rd_en
//   busy     : check in progress
//   done     : one-cycle completion pulse
//   flag     : 1 = norm exceeded or bound invalid
//   fail_idx : index of first violating coefficient (all-ones = bad bound)
// master = requester/memory side, slave = checker side.
// ---------------------------------------------------------------------------
interface polyvecl_chknorm_seq_if #(
  parameter int AW = 11
);
  logic                 start;
  logic signed [31:0]   B;
  logic                 rd_en;
  logic        [AW-1:0] rd_addr;
  logic signed [31:0]   rd_data;
  logic                 busy;
  logic                 done;
  logic                 flag;
  logic        [AW-1:0] fail_idx;

  modport master (
    output start, B, rd_data,
    input  rd_en, rd_addr, busy, done, flag, fail_idx
  );

  modport slave (
    input  start, B, rd_data,
    output rd_en, rd_addr, busy, done, flag, fail_idx
  );
endinterface

// File: rtl/polyvecl_chknorm_seq.sv
// ---------------------------------------------------------------------------
// polyvecl_chknorm_seq
// Sequential infinity-norm check of a vector of L polynomials with N
// coefficients each. The coefficients are streamed from an external memory
// with one-cycle read latency; the first coefficient with |c| >= B sets
// flag and records its index. A bound above (Q-1)/8 is rejected without
// any reads.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : polyvecl_chknorm_seq_if.slave (start/B in, memory read port,
//          busy/done/flag/fail_idx out)
// ---------------------------------------------------------------------------
module polyvecl_chknorm_seq #(
  parameter int L  = 5,
  parameter int N  = 256,
  parameter int Q  = 8380417,
  parameter int AW = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  polyvecl_chknorm_seq_if.slave   bus
);

  localparam int                 TOTAL     = L * N;
  localparam logic [AW-1:0]      LAST_ADDR = AW'(TOTAL - 1);
  localparam logic signed [31:0] B_MAX     = 32'((Q - 1) / 8);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // |c| in 33 bits so that c = -2^31 maps to +2^31 instead of wrapping.
  function automatic logic signed [32:0] abs33(input logic signed [31:0] c);
    logic signed [32:0] cx;
    cx = {c[31], c};
    return (cx < 0) ? -cx : cx;
  endfunction

  // Violation when |c| >= B, compared as signed so that B <= 0 always trips.
  function automatic logic violates(input logic signed [31:0] c,
                                    input logic signed [31:0] b);
    logic signed [32:0] bx;
    bx = {b[31], b};
    return abs33(c) >= bx;
  endfunction

  logic signed [31:0] b_reg;
  logic               rd_active;
  logic [AW-1:0]      rd_addr_q;
  logic               vld_p1;
  logic [AW-1:0]      idx_p1;
  logic               flag_q;
  logic [AW-1:0]      fail_idx_q;

  logic start_acc;
  logic b_bad;
  logic viol_p1;
  logic last_p1;

  // The bound check uses the live B input so a bad bound reaches DONE in
  // the cycle right after acceptance; it equals the value being registered.
  assign start_acc = (state == IDLE) && bus.start;
  assign b_bad     = bus.B > B_MAX;

  // Compare stage only acts while RUN; returned data arriving after a
  // violation (state already DONE) is ignored.
  assign viol_p1 = (state == RUN) && vld_p1 && violates(bus.rd_data, b_reg);
  assign last_p1 = (state == RUN) && vld_p1 && (idx_p1 == LAST_ADDR);

  // ---- FSM state register ----
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ---- FSM next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = b_bad ? DONE : RUN;
      end
      RUN: begin
        if (viol_p1 || last_p1) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.busy     = (state == RUN);
  assign bus.done     = (state == DONE);
  assign bus.rd_en    = rd_active;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.flag     = flag_q;
  assign bus.fail_idx = fail_idx_q;

  // ---- stage p0: read issue, bound register, result latches ----
  always_ff @(posedge clk) begin
    if (rst) begin
      b_reg      <= '0;
      rd_active  <= 1'b0;
      rd_addr_q  <= '0;
      vld_p1     <= 1'b0;
      flag_q     <= 1'b0;
      fail_idx_q <= '0;
    end else begin
      // A read is only worth comparing if no violation stops the run now.
      vld_p1 <= rd_active && !viol_p1;
      if (start_acc) begin
        b_reg      <= bus.B;
        flag_q     <= b_bad;
        fail_idx_q <= b_bad ? '1 : '0;
        rd_active  <= !b_bad;
        rd_addr_q  <= '0;
      end else if (state == RUN) begin
        if (viol_p1) begin
          flag_q     <= 1'b1;
          fail_idx_q <= idx_p1;
          rd_active  <= 1'b0;
        end else if (rd_active) begin
          // Stop after the last address rather than wrapping to zero.
          if (rd_addr_q == LAST_ADDR) rd_active <= 1'b0;
          else                        rd_addr_q <= rd_addr_q + AW'(1);
        end
      end else begin
        rd_active <= 1'b0;
      end
    end
  end

  // ---- stage p1: index of the coefficient now on rd_data ----
  always_ff @(posedge clk) begin
    idx_p1 <= rd_addr_q;
  end

endmodule

// File: tb/tb_polyvecl_chknorm_seq.sv
// ---------------------------------------------------------------------------
// tb_polyvecl_chknorm_seq
// Self-checking bench for polyvecl_chknorm_seq: directed vector table,
// hand-written reset/start-ignore sequences and randomized vectors checked
// against a plain reference model of the norm check.
// ---------------------------------------------------------------------------
module tb_polyvecl_chknorm_seq;
  localparam int L     = 5;
  localparam int N     = 256;
  localparam int Q     = 8380417;
  localparam int AW    = 11;
  localparam int TOTAL = L * N;
  localparam int ONES  = (1 << AW) - 1;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  logic signed [31:0] mem [0:(1<<AW)-1];

  polyvecl_chknorm_seq_if #(.AW(AW)) bus ();

  polyvecl_chknorm_seq #(.L(L), .N(N), .Q(Q), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient memory: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    else           bus.rd_data <= $urandom;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: first index with |c| >= B, or bound rejection.
  function automatic void ref_model(input logic signed [31:0] b, output bit f,
                                    output int idx, output int dc);
    longint bl;
    longint c;
    bl  = b;
    f   = 1'b0;
    idx = 0;
    dc  = TOTAL + 2;
    if (bl > (Q - 1) / 8) begin
      f = 1'b1; idx = ONES; dc = 1;
      return;
    end
    for (int i = 0; i < TOTAL; i++) begin
      c = mem[i];
      if (c < 0) c = -c;
      if (c >= bl) begin
        f = 1'b1; idx = i; dc = i + 3;
        return;
      end
    end
  endfunction

  // One check: start in cycle 0, observe every cycle until done.
  task automatic run(input string name, input logic signed [31:0] b,
                     input bit ef, input int ei, input int ed,
                     input bit pulse_busy, input bit start_at_done);
    int reads, bad_order, maxaddr, done_cyc, busy_bad;
    logic busy_at_done, rden_outside;
    logic hold_f;
    logic [AW-1:0] hold_i;
    reads = 0; bad_order = 0; maxaddr = -1; done_cyc = -1; busy_bad = 0;
    busy_at_done = 1'b1; rden_outside = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.B     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.B     = $urandom;
    for (int c = 1; c < 3000; c++) begin
      bus.start = (pulse_busy && c == 10);
      if (pulse_busy && c == 10) bus.B = 0;
      if (bus.rd_en) begin
        if (int'(bus.rd_addr) != reads) bad_order++;
        if (int'(bus.rd_addr) > maxaddr) maxaddr = int'(bus.rd_addr);
        reads++;
        if (!bus.busy) rden_outside = 1'b1;
      end
      if (bus.done) begin
        done_cyc     = c;
        busy_at_done = bus.busy;
        break;
      end
      if (!bus.busy) busy_bad++;
      @(negedge clk);
    end
    chk({name, " done_cycle"}, done_cyc, ed);
    chk({name, " flag"}, bus.flag, ef);
    chk({name, " fail_idx"}, bus.fail_idx, ei);
    chk({name, " busy_window"}, {busy_at_done, rden_outside, 30'(busy_bad)}, 0);
    chk({name, " read_order"}, bad_order, 0);
    if (ed == 1)      chk({name, " reads"}, reads, 0);
    else if (!ef)     chk({name, " reads"}, reads, TOTAL);
    else              chk({name, " reads_bounded"},
                          (maxaddr <= ei + 1) && (reads >= ei + 1), 1);
    hold_f = bus.flag;
    hold_i = bus.fail_idx;
    if (start_at_done) bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.busy || bus.done || bus.rd_en) busy_bad++;
      @(negedge clk);
    end
    chk({name, " idle_after_done"}, busy_bad, 0);
    chk({name, " hold"}, {bus.flag, bus.fail_idx}, {hold_f, hold_i});
  endtask

  typedef struct {
    logic signed [31:0] b;
    int                 pat;    // 0: all zero, 1: random in [-100,100]
    int                 sidx;   // planted coefficient index, -1 none
    logic signed [31:0] sval;
    bit                 ef;
    int                 ei;
    int                 ed;
    bit                 pulse;
    bit                 sdone;
  } vec_t;

  task automatic fill(input int pat, input int sidx, input logic signed [31:0] sval);
    for (int i = 0; i < (1 << AW); i++)
      mem[i] = (pat == 1) ? 32'(int'($urandom_range(200)) - 100) : 32'sd0;
    if (sidx >= 0) mem[sidx] = sval;
  endtask

  initial begin
    vec_t vt[$];
    bit   mf;
    int   mi, md, nd;
    logic signed [31:0] rb;

    tests = 0; failed = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.B     = '0;
    fill(0, -1, 0);

    vt.push_back('{32'sd101,         1, -1,   32'sd0,   0, 0,    1282, 1, 0});
    vt.push_back('{32'sd101,         0, 700,  -32'sd101, 1, 700, 703,  1, 1});
    vt.push_back('{32'sd1047553,     0, -1,   32'sd0,   1, ONES, 1,    0, 1});
    vt.push_back('{32'sd1047552,     0, -1,   32'sd0,   0, 0,    1282, 0, 0});
    vt.push_back('{32'sd1000,        0, 1279, 32'h80000000, 1, 1279, 1282, 0, 0});
    vt.push_back('{32'sd0,           0, -1,   32'sd0,   1, 0,    3,    0, 1});
    vt.push_back('{-32'sd5,          0, -1,   32'sd0,   1, 0,    3,    0, 0});
    vt.push_back('{32'h80000000,     0, -1,   32'sd0,   1, 0,    3,    0, 0});
    vt.push_back('{32'sd101,         1, 0,    32'sd101, 1, 0,    3,    0, 0});
    vt.push_back('{32'sd101,         1, 1279, -32'sd100, 0, 0,   1282, 0, 0});
    vt.push_back('{32'sd261889,      0, -1,   32'sd0,   0, 0,    1282, 0, 0});

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_state", {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.flag, bus.fail_idx}, 0);

    foreach (vt[i]) begin
      fill(vt[i].pat, vt[i].sidx, vt[i].sval);
      run($sformatf("vec%0d", i), vt[i].b, vt[i].ef, vt[i].ei, vt[i].ed,
          vt[i].pulse, vt[i].sdone);
    end

    // Reset at cycle 500 of a run (with start held during reset).
    fill(0, -1, 0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.B     = 32'sd101;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (499) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    chk("rst_abort_state", {bus.busy, bus.done, bus.rd_en, bus.rd_addr, bus.flag, bus.fail_idx}, 0);
    nd = 0;
    for (int c = 0; c < 1300; c++) begin
      if (bus.done || bus.busy || bus.rd_en) nd++;
      @(negedge clk);
    end
    chk("rst_abort_no_done", nd, 0);
    run("after_rst", 32'sd101, 1'b0, 0, TOTAL + 2, 1'b1, 1'b0);

    // Randomized vectors against the reference model.
    for (int r = 0; r < 10; r++) begin
      case (r % 4)
        0: begin
          for (int i = 0; i < TOTAL; i++) mem[i] = 32'(int'($urandom_range(2000)) - 1000);
          rb = 32'(990 + int'($urandom_range(15)));
        end
        1: begin
          for (int i = 0; i < TOTAL; i++) mem[i] = 32'(int'($urandom_range(4)) - 2);
          rb = 32'(int'($urandom_range(4)) - 1);
        end
        2: begin
          for (int i = 0; i < TOTAL; i++) mem[i] = $urandom;
          rb = 32'(1047553 + int'($urandom_range(1000000)));
        end
        default: begin
          for (int i = 0; i < TOTAL; i++) mem[i] = 32'(int'($urandom_range(100)) - 50);
          mem[$urandom_range(TOTAL - 1)] = 32'h80000000;
          rb = 32'sd51;
        end
      endcase
      ref_model(rb, mf, mi, md);
      run($sformatf("rand%0d", r), rb, mf, mi, md, 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
